// File: rtl/rs_issue_arbiter_if.sv
// Issue-arbiter bundle between the reservation station and the issue stage.
//   master : RS/issue side, drives candidate info, samples grants
//   slave  : arbiter, samples candidate info, drives grants
//   rs_valid_issue/entry_ready : per-entry candidate qualifiers
//   entry_fu        : 2-bit FU class per entry (0 ALU, 1 MULT, 2 LDST, 3 BR)
//   ldst_ready      : load/store unit can take one op this cycle
//   b_mm_mispred    : squash all grants this cycle
//   rs_data_issuing : per-entry grant vector back to the RS
//   issue_valid     : per-slot grant valid
//   issue_idx       : per-slot granted RS index, slot k at [k*IDX_W +: IDX_W]
//   mult_busy       : multiplier occupied
interface rs_issue_arbiter_if #(
  parameter int unsigned RS_SZ = 16,
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = $clog2(RS_SZ)
);
  logic [RS_SZ-1:0]   rs_valid_issue;
  logic [RS_SZ-1:0]   entry_ready;
  logic [RS_SZ*2-1:0] entry_fu;
  logic               ldst_ready;
  logic               b_mm_mispred;
  logic [RS_SZ-1:0]   rs_data_issuing;
  logic [N-1:0]       issue_valid;
  logic [N*IDX_W-1:0] issue_idx;
  logic               mult_busy;

  modport master (
    output rs_valid_issue, entry_ready, entry_fu, ldst_ready, b_mm_mispred,
    input  rs_data_issuing, issue_valid, issue_idx, mult_busy
  );

  modport slave (
    input  rs_valid_issue, entry_ready, entry_fu, ldst_ready, b_mm_mispred,
    output rs_data_issuing, issue_valid, issue_idx, mult_busy
  );
endinterface

// File: rtl/rs_issue_arbiter.sv
// Reservation-station issue arbiter: picks up to N ready entries per cycle in
// rotating-priority order under per-FU-class limits, and tracks occupancy of
// the single non-pipelined multiplier.
//   i_clk : system clock
//   i_rst : asynchronous active-high reset; also gates all grants
//   bus   : rs_issue_arbiter_if slave modport (candidates in, grants out)
// Grants are combinational from the inputs; rr_ptr and mult_cnt are registered.
module rs_issue_arbiter #(
  parameter int unsigned RS_SZ    = 16,
  parameter int unsigned N        = 3,
  parameter int unsigned MULT_LAT = 4,
  parameter int unsigned IDX_W    = $clog2(RS_SZ)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  rs_issue_arbiter_if.slave    bus
);

  localparam int unsigned SUM_W  = IDX_W + 1;
  localparam int unsigned SLOT_W = $clog2(N + 1);
  localparam int unsigned CNT_W  = $clog2(MULT_LAT + 1);

  localparam logic [1:0] FU_ALU  = 2'd0;
  localparam logic [1:0] FU_MULT = 2'd1;
  localparam logic [1:0] FU_LDST = 2'd2;

  logic [IDX_W-1:0]   r_rr_ptr;
  logic [CNT_W-1:0]   r_mult_cnt;

  logic [RS_SZ-1:0]   w_cand;
  logic [1:0]         w_fu [RS_SZ];
  logic [RS_SZ-1:0]   w_issuing;
  logic [N-1:0]       w_valid;
  logic [N*IDX_W-1:0] w_idx_bus;
  logic [SLOT_W-1:0]  w_tot;
  logic [SLOT_W-1:0]  w_alu;
  logic               w_br;
  logic               w_ldst;
  logic               w_mult;
  logic [IDX_W-1:0]   w_last;
  logic [IDX_W-1:0]   w_next_ptr;
  logic [SUM_W-1:0]   w_next_sum;

  assign w_cand = bus.rs_valid_issue & bus.entry_ready;

  // Unpack FU classes so the scan can index them by entry number.
  for (genvar g = 0; g < RS_SZ; g++) begin : g_fu
    assign w_fu[g] = bus.entry_fu[2*g +: 2];
  end

  // Rotating-priority scan; a candidate blocked by its class limit is skipped.
  always_comb begin
    w_issuing = '0;
    w_valid   = '0;
    w_idx_bus = '0;
    w_tot     = '0;
    w_alu     = '0;
    w_br      = 1'b0;
    w_ldst    = 1'b0;
    w_mult    = 1'b0;
    w_last    = '0;
    for (int unsigned k = 0; k < RS_SZ; k++) begin : g_scan
      logic [SUM_W-1:0] sum;
      logic [IDX_W-1:0] idx;
      logic             ok;
      sum = {1'b0, r_rr_ptr} + SUM_W'(k);
      if (sum >= SUM_W'(RS_SZ)) sum = sum - SUM_W'(RS_SZ);
      idx = sum[IDX_W-1:0];
      ok  = 1'b0;
      if (!i_rst && !bus.b_mm_mispred && w_cand[idx] && (w_tot < SLOT_W'(N))) begin
        case (w_fu[idx])
          FU_ALU:  ok = (w_alu < SLOT_W'(N));
          FU_MULT: ok = !w_mult && (r_mult_cnt == '0);
          FU_LDST: ok = !w_ldst && bus.ldst_ready;
          default: ok = !w_br;
        endcase
      end
      if (ok) begin
        w_issuing[idx] = 1'b1;
        for (int unsigned s = 0; s < N; s++) begin
          if (w_tot == SLOT_W'(s)) begin
            w_valid[s]                 = 1'b1;
            w_idx_bus[s*IDX_W +: IDX_W] = idx;
          end
        end
        case (w_fu[idx])
          FU_ALU:  w_alu  = w_alu + SLOT_W'(1);
          FU_MULT: w_mult = 1'b1;
          FU_LDST: w_ldst = 1'b1;
          default: w_br   = 1'b1;
        endcase
        w_tot  = w_tot + SLOT_W'(1);
        w_last = idx;
      end
    end
  end

  // Pointer moves to one past the last-slot grant, wrapping at RS_SZ.
  always_comb begin
    w_next_sum = {1'b0, w_last} + SUM_W'(1);
    if (w_next_sum >= SUM_W'(RS_SZ)) w_next_sum = w_next_sum - SUM_W'(RS_SZ);
    w_next_ptr = w_next_sum[IDX_W-1:0];
  end

  // Fairness pointer and multiplier occupancy; a squashed multiply still drains.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rr_ptr   <= '0;
      r_mult_cnt <= '0;
    end else begin
      if (w_tot != '0) r_rr_ptr <= w_next_ptr;
      if (w_mult)                 r_mult_cnt <= CNT_W'(MULT_LAT - 1);
      else if (r_mult_cnt != '0)  r_mult_cnt <= r_mult_cnt - CNT_W'(1);
    end
  end

  assign bus.rs_data_issuing = w_issuing;
  assign bus.issue_valid     = w_valid;
  assign bus.issue_idx       = w_idx_bus;
  assign bus.mult_busy       = (r_mult_cnt != '0);

endmodule
